ram_ctrl: RTL
=============

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4, the number of RD_WAIT cycles allowed for mem_valid before an error response.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1, host command present.
REQ-005 SHALL have port cmd_ready, output, 1, controller accepts a command.
REQ-006 SHALL have port cmd_we, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, 4, start address.
REQ-008 SHALL have port cmd_wdata, input, 8, write data.
REQ-009 SHALL have port cmd_len, input, 4, burst length minus one (RAM_CTRL_BURST_EN only).
REQ-010 SHALL have port rsp_valid, output, 1, read response present.
REQ-011 SHALL have port rsp_ready, input, 1, host accepts the response.
REQ-012 SHALL have port rsp_data, output, 8, read data.
REQ-013 SHALL have port rsp_err, output, 1, read timed out.
REQ-014 SHALL have port mem_ce, output, 1, memory chip enable.
REQ-015 SHALL have port mem_rd_en, output, 1, memory read enable.
REQ-016 SHALL have port mem_wr_en, output, 1, memory write enable.
REQ-017 SHALL have port mem_addr, output, 4, memory address.
REQ-018 SHALL have port mem_wdata, output, 8, memory write data.
REQ-019 SHALL have port mem_rdata, input, 8, memory read data; valid only while ce and rd_en are held.
REQ-020 SHALL have port mem_valid, input, 1, memory read-data valid, asserted one cycle after a read is issued.

Function
REQ-021 SHALL implement an FSM with states IDLE, WR, RD_REQ, RD_WAIT and RSP; all outputs SHALL be registered.
REQ-022 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&cmd_ready, and addr/we/wdata/len are latched at that edge.
REQ-023 Write, accept at edge T: the FSM SHALL enter WR for one cycle with mem_ce=1, mem_wr_en=1, mem_addr and mem_wdata driven; no response is generated.
REQ-024 Read, accept at edge T: the FSM SHALL enter RD_REQ for one cycle with mem_ce=1 and mem_rd_en=1, then RD_WAIT with mem_ce and mem_rd_en still held.
REQ-025 In RD_WAIT, on mem_valid=1 the controller SHALL capture mem_rdata into rsp_data, set rsp_err=0, and enter RSP with rsp_valid=1; minimum latency is acceptance edge to rsp_valid = 3 cycles.
REQ-026 If mem_valid is not seen within TIMEOUT RD_WAIT cycles, the controller SHALL enter RSP with rsp_data=8'h00 and rsp_err=1.
REQ-027 In RSP, mem_ce, mem_rd_en and mem_wr_en SHALL be 0; rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_valid&rsp_ready.
REQ-028 After the response handshake, the controller SHALL go to IDLE, or to RD_REQ for the next beat if a burst remains; rsp_valid SHALL drop in the same cycle unless a new response is ready.
REQ-029 mem_rd_en and mem_wr_en SHALL never be asserted together, and SHALL never be asserted without mem_ce.
REQ-030 mem_valid outside RD_WAIT SHALL be ignored.

Reset
REQ-031 While rst=1 at a clock edge, all outputs SHALL be 0 (cmd_ready=0, rsp_valid=0, rsp_data=8'h00, rsp_err=0, all mem_* = 0), the FSM SHALL be in IDLE, and all counters SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abort it; a pending response or beat SHALL be discarded, and cmd_ready=1 SHALL follow on the first edge after rst deasserts.

Configuration
REQ-033 With macro RAM_CTRL_BURST_EN defined, a command SHALL perform cmd_len+1 beats at addresses incrementing modulo 16 (15 wraps to 0); write bursts SHALL fill each address with cmd_wdata in consecutive WR cycles, and read bursts SHALL return one response per beat in address order.
REQ-034 Without RAM_CTRL_BURST_EN, cmd_len SHALL be ignored, every command SHALL perform exactly one beat, and no beat counter SHALL be implemented.

Verification
REQ-035 Write 0xA5 to addr 3, then read addr 3 against the memory model: mem_wr_en pulses 1 cycle; rsp_valid=1 three cycles after read acceptance, rsp_data=0xA5, rsp_err=0.
REQ-036 Read addr 7 with mem_valid tied 0 and TIMEOUT=4: rsp_valid after 4 RD_WAIT cycles, rsp_data=0x00, rsp_err=1.
REQ-037 Read with rsp_ready held 0 for 5 cycles: rsp_valid and rsp_data stay stable; cmd_ready=0 until the handshake, then cmd_ready=1 next cycle.
REQ-038 With RAM_CTRL_BURST_EN defined: burst write of 0x3C to addr 14 with len=2, then burst read addr 14 len=2: mem_addr sequence is 14,15,0; three responses all 0x3C.
REQ-039 Assert rst=1 during RD_WAIT: next cycle all outputs are 0 and no response appears; after rst deasserts, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - single-port RAM controller with read timeout; optional bursts under macro RAM_CTRL_BURST_EN
module ram_ctrl #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [3:0] cmd_len,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       mem_ce,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_valid
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RSP} state_t;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             mem_ce_q, mem_ce_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic             mem_wr_en_q, mem_wr_en_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             last_beat;

`ifdef RAM_CTRL_BURST_EN
  logic [3:0]       beat_q, beat_d;
  assign last_beat = (beat_q == 4'd0);
`else
  // Single-beat build: the length field has no effect.
  logic             unused_len;
  assign unused_len = ^cmd_len;
  assign last_beat  = 1'b1;
`endif

  // Next-state and next-output computation; every output is a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_ce_d    = mem_ce_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_wr_en_d = mem_wr_en_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
`ifdef RAM_CTRL_BURST_EN
    beat_d      = beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
`ifdef RAM_CTRL_BURST_EN
          beat_d      = cmd_len;
`endif
          cmd_ready_d = 1'b0;
          mem_ce_d    = 1'b1;
          if (cmd_we) begin
            state_d     = WR;
            mem_wr_en_d = 1'b1;
          end else begin
            state_d     = RD_REQ;
            mem_rd_en_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      WR: begin
        if (!last_beat) begin
          addr_d = addr_q + 4'd1;
`ifdef RAM_CTRL_BURST_EN
          beat_d = beat_q - 4'd1;
`endif
        end else begin
          state_d     = IDLE;
          mem_ce_d    = 1'b0;
          mem_wr_en_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      RD_REQ: begin
        state_d    = RD_WAIT;
        wait_cnt_d = '0;
      end
      RD_WAIT: begin
        // Data arriving on the last allowed cycle wins over the timeout.
        if (mem_valid) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rdata;
          rsp_err_d   = 1'b0;
          mem_ce_d    = 1'b0;
          mem_rd_en_d = 1'b0;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
          mem_ce_d    = 1'b0;
          mem_rd_en_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!last_beat) begin
            state_d     = RD_REQ;
            addr_d      = addr_q + 4'd1;
`ifdef RAM_CTRL_BURST_EN
            beat_d      = beat_q - 4'd1;
`endif
            mem_ce_d    = 1'b1;
            mem_rd_en_d = 1'b1;
          end else begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset clears every output, counter and pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      addr_q      <= 4'd0;
      wdata_q     <= 8'h00;
      wait_cnt_q  <= '0;
`ifdef RAM_CTRL_BURST_EN
      beat_q      <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_ce_q    <= mem_ce_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
`ifdef RAM_CTRL_BURST_EN
      beat_q      <= beat_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_ce    = mem_ce_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
